run_ctrl: RTL and testbench
===========================

# run_ctrl

Parametrised run-control unit for the processor test harness. It sequences core reset and a configurable reset-hold period, then runs the core under a cycle budget. It detects program halt (PC jump-to-self) or budget exhaustion and freezes the core via a run enable. It exposes a saturating cycle counter and per-channel event counters so benches and on-board debug share one termination and statistics mechanism.

## Interface
- RST_CYCLES, 2: cycles core_reset_o stays high after reset deasserts (≥1)
- MAX_CYCLES, 100: RUN-state cycle budget before timeout (1 ≤ MAX_CYCLES ≤ 2^CNT_WIDTH−1)
- PC_WIDTH, 32: width of monitored PC
- CNT_WIDTH, 16: width of cycle and event counters
- NUM_EVT, 4: number of event counter channels (≥1)
- HALT_REPEAT, 3: consecutive repeated valid PCs that declare halt (≥1)

- clk  in  1  single clock, rising edge
- reset  in  1  asynchronous, active-low; deassertion synchronised upstream
- pc_i  in  PC_WIDTH  core PC of current instruction
- pc_valid_i  in  1  pc_i valid this cycle (instruction retired)
- evt_i  in  NUM_EVT  per-channel event strobes
- core_reset_o  out  1  active-high reset to core
- run_o  out  1  core clock enable
- done_o  out  1  halt detected (sticky)
- timeout_o  out  1  budget exhausted (sticky)
- state_o  out  2  current FSM state
- cycle_cnt_o  out  CNT_WIDTH  RUN cycles elapsed
- evt_cnt_o  out  NUM_EVT*CNT_WIDTH  event counts, channel k at bits [k*CNT_WIDTH +: CNT_WIDTH]

## Operation
- States: HOLD(0), RUN(1), HALTED(2), TIMEOUT(3).
- Reset values: state HOLD, core_reset_o=1, run_o=0, done_o=0, timeout_o=0, all counters 0, halt tracker cleared.
- HOLD: core_reset_o=1, run_o=0; hold counter increments each cycle; after RST_CYCLES cycles -> RUN.
- RUN: core_reset_o=0, run_o=1; cycle_cnt increments every cycle.
- Halt tracker: on a pc_valid_i cycle, if pc_i equals the last valid PC, the repeat count increments, otherwise it resets to 0 and the last PC is updated. Invalid cycles leave the tracker unchanged. Repeat count reaching HALT_REPEAT in RUN -> HALTED.
- Timeout: in the RUN cycle where cycle_cnt == MAX_CYCLES−1, the next state is TIMEOUT.
- Simultaneous halt and timeout in the same cycle: HALTED wins; timeout_o stays 0.
- HALTED/TIMEOUT: terminal until reset. run_o=0, core_reset_o=0 (core state preserved for inspection). The matching sticky flag is 1. Counters freeze.
- Event counters: channel k increments when evt_i[k]=1 in RUN only. Counters saturate at all-ones and never wrap. The cycle counter also saturates.
- Reset asserted mid-RUN: all state returns to reset values immediately, regardless of clock.

## Timing
- All outputs are registered; no combinational input-to-output paths.
- core_reset_o falls and run_o rises on the same edge: RST_CYCLES rising edges after reset deasserts.
- Halt flags assert one cycle after the qualifying pc_valid_i sample.
- For MAX_CYCLES=N with no halt, run_o is high for exactly N cycles. Then timeout_o=1 and cycle_cnt_o=N.
- Event strobes in the same cycle as the RUN→terminal transition are counted.

## Configuration
- RUN_CTRL_EVT_EN defined: NUM_EVT saturating event counters are built.
- Undefined: no counter logic; evt_cnt_o is tied to 0 and evt_i is ignored. FSM, cycle counter and halt detection are unchanged.

## Structure
- Package run_ctrl_pkg holds the state typedef/encoding (HOLD, RUN, HALTED, TIMEOUT) and STATE_W=2.
- Sub-module run_ctrl_sat_cnt: parametrised CNT_WIDTH saturating counter with enable and async active-low clear. It is used for the cycle counter and each event channel.

## Test plan
- RST_CYCLES=2: release reset -> core_reset_o high for exactly 2 cycles, then run_o=1, state_o=1.
- MAX_CYCLES=100, PC incrementing by 4 every cycle -> timeout_o=1 after 100 RUN cycles, cycle_cnt_o=100, run_o=0, done_o=0.
- PC sequence 0x0,0x4,0x8,0x8,0x8,0x8 (HALT_REPEAT=3) -> done_o=1 one cycle after the third repeat, state_o=2, timeout_o=0.
- Halt and budget coincide: third repeat lands on cycle 99 of MAX_CYCLES=100 -> done_o=1, timeout_o=0.
- CNT_WIDTH=4, evt_i[1] held high 20 RUN cycles -> channel 1 reads 15 (saturated), channel 0 reads 0; undefined RUN_CTRL_EVT_EN -> all 0.
- Reset asserted at RUN cycle 50 -> all outputs immediately return to reset values; on release the HOLD sequence restarts and counters start from 0.

Source files
------------

// File: rtl/run_ctrl_pkg.sv
// Shared definitions for the run-control unit: FSM state encoding and its width.
package run_ctrl_pkg;

    localparam int STATE_W = 2;

    typedef enum logic [STATE_W-1:0] {
        HOLD    = 2'd0,
        RUN     = 2'd1,
        HALTED  = 2'd2,
        TIMEOUT = 2'd3
    } run_state_e;

endpackage

// File: rtl/run_ctrl_sat_cnt.sv
// Saturating up-counter with enable and asynchronous active-low clear.
// Used for the RUN cycle counter and for every event channel.
module run_ctrl_sat_cnt #(
    parameter int CNT_WIDTH = 16
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 en,
    output logic [CNT_WIDTH-1:0] cnt
);

    // Holds at all-ones instead of wrapping so long runs never alias to small counts.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt <= '0;
        end else if (en && (cnt != '1)) begin
            cnt <= cnt + 1'b1;
        end
    end

endmodule

// File: rtl/run_ctrl.sv
// Run-control unit: core reset hold, cycle-budgeted RUN, halt (PC jump-to-self) detection.
// Optional macro RUN_CTRL_EVT_EN builds the per-channel saturating event counters.
module run_ctrl
    import run_ctrl_pkg::*;
#(
    parameter int RST_CYCLES  = 2,
    parameter int MAX_CYCLES  = 100,
    parameter int PC_WIDTH    = 32,
    parameter int CNT_WIDTH   = 16,
    parameter int NUM_EVT     = 4,
    parameter int HALT_REPEAT = 3
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic [PC_WIDTH-1:0]            pc_i,
    input  logic                           pc_valid_i,
    input  logic [NUM_EVT-1:0]             evt_i,
    output logic                           core_reset_o,
    output logic                           run_o,
    output logic                           done_o,
    output logic                           timeout_o,
    output logic [STATE_W-1:0]             state_o,
    output logic [CNT_WIDTH-1:0]           cycle_cnt_o,
    output logic [NUM_EVT*CNT_WIDTH-1:0]   evt_cnt_o
);

    localparam int HOLD_W = $clog2(RST_CYCLES + 1);
    localparam int REP_W  = $clog2(HALT_REPEAT + 1);
    localparam logic [HOLD_W-1:0]    HOLD_LAST = HOLD_W'(RST_CYCLES - 1);
    localparam logic [REP_W-1:0]     REP_MAX   = REP_W'(HALT_REPEAT);
    localparam logic [CNT_WIDTH-1:0] CNT_LAST  = CNT_WIDTH'(MAX_CYCLES - 1);

    run_state_e            state, state_nxt;
    logic [HOLD_W-1:0]     hold_cnt;
    logic [PC_WIDTH-1:0]   last_pc, last_pc_nxt;
    logic                  last_vld, last_vld_nxt;
    logic [REP_W-1:0]      rep_cnt, rep_nxt;
    logic                  halt_hit;
    logic                  run_st;
    logic [CNT_WIDTH-1:0]  cycle_cnt;

    assign run_st      = (state == RUN);
    assign state_o     = state;
    assign cycle_cnt_o = cycle_cnt;

    // last_vld keeps the first valid PC after reset from matching the cleared last_pc.
    always_comb begin
        last_pc_nxt  = last_pc;
        last_vld_nxt = last_vld;
        rep_nxt      = rep_cnt;
        if (pc_valid_i) begin
            if (last_vld && (pc_i == last_pc)) begin
                if (rep_cnt != REP_MAX) begin
                    rep_nxt = rep_cnt + 1'b1;
                end
            end else begin
                rep_nxt      = '0;
                last_pc_nxt  = pc_i;
                last_vld_nxt = 1'b1;
            end
        end
        halt_hit = (rep_nxt == REP_MAX);
    end

    always_comb begin
        state_nxt = state;
        case (state)
            HOLD: begin
                if (hold_cnt == HOLD_LAST) begin
                    state_nxt = RUN;
                end
            end
            RUN: begin
                if (halt_hit) begin
                    state_nxt = HALTED;
                end else if (cycle_cnt == CNT_LAST) begin
                    state_nxt = TIMEOUT;
                end
            end
            default: state_nxt = state;
        endcase
    end

    // Outputs are decoded from the next state so they flop on the same edge as the state.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state        <= HOLD;
            hold_cnt     <= '0;
            last_pc      <= '0;
            last_vld     <= 1'b0;
            rep_cnt      <= '0;
            core_reset_o <= 1'b1;
            run_o        <= 1'b0;
            done_o       <= 1'b0;
            timeout_o    <= 1'b0;
        end else begin
            state        <= state_nxt;
            last_pc      <= last_pc_nxt;
            last_vld     <= last_vld_nxt;
            rep_cnt      <= rep_nxt;
            core_reset_o <= (state_nxt == HOLD);
            run_o        <= (state_nxt == RUN);
            done_o       <= (state_nxt == HALTED);
            timeout_o    <= (state_nxt == TIMEOUT);
            if ((state == HOLD) && (hold_cnt != HOLD_LAST)) begin
                hold_cnt <= hold_cnt + 1'b1;
            end
        end
    end

    run_ctrl_sat_cnt #(
        .CNT_WIDTH(CNT_WIDTH)
    ) u_cycle_cnt (
        .clk  (clk),
        .reset(reset),
        .en   (run_st),
        .cnt  (cycle_cnt)
    );

`ifdef RUN_CTRL_EVT_EN
    // A strobe on the RUN->terminal edge still sees state==RUN, so it is counted.
    for (genvar k = 0; k < NUM_EVT; k++) begin : g_evt
        run_ctrl_sat_cnt #(
            .CNT_WIDTH(CNT_WIDTH)
        ) u_evt_cnt (
            .clk  (clk),
            .reset(reset),
            .en   (run_st & evt_i[k]),
            .cnt  (evt_cnt_o[k*CNT_WIDTH +: CNT_WIDTH])
        );
    end
`else
    logic evt_unused;
    assign evt_unused = ^evt_i;
    assign evt_cnt_o  = '0;
`endif

endmodule

// File: tb/tb_run_ctrl.sv
// Self-checking bench for run_ctrl: hold sequence, timeout, halt, halt/timeout tie,
// mid-run reset, and counter saturation on a narrow-counter instance.
module tb_run_ctrl;

    localparam int MAXC = 100;

`ifdef RUN_CTRL_EVT_EN
    localparam bit EVT_EN = 1'b1;
`else
    localparam bit EVT_EN = 1'b0;
`endif

    typedef struct {
        int          p;
        logic        cr;
        logic        run;
        logic        done;
        logic        to;
        logic [1:0]  st;
        logic [15:0] cnt;
    } exp_t;

    typedef struct {
        logic        v;
        logic [31:0] pc;
        exp_t        e;
    } vec_t;

    logic        clk;
    logic        reset;
    logic [31:0] pc;
    logic        pc_valid;
    logic [3:0]  evt;
    logic        core_reset, run, done, timeout;
    logic [1:0]  state;
    logic [15:0] cycle_cnt;
    logic [63:0] evt_cnt;

    logic        reset4;
    logic [31:0] pc4;
    logic        pc_valid4;
    logic [3:0]  evt4;
    logic        core_reset4, run4, done4, timeout4;
    logic [1:0]  state4;
    logic [3:0]  cycle_cnt4;
    logic [15:0] evt_cnt4;

    logic        sc_reset;
    logic        sc_en;
    logic [3:0]  sc_cnt;

    int   tests_run;
    int   tests_failed;
    exp_t sb_q[$];
    vec_t tbl[11];

    run_ctrl #(
        .RST_CYCLES(2), .MAX_CYCLES(MAXC), .PC_WIDTH(32),
        .CNT_WIDTH(16), .NUM_EVT(4), .HALT_REPEAT(3)
    ) dut (
        .clk(clk), .reset(reset), .pc_i(pc), .pc_valid_i(pc_valid), .evt_i(evt),
        .core_reset_o(core_reset), .run_o(run), .done_o(done), .timeout_o(timeout),
        .state_o(state), .cycle_cnt_o(cycle_cnt), .evt_cnt_o(evt_cnt)
    );

    run_ctrl #(
        .RST_CYCLES(1), .MAX_CYCLES(15), .PC_WIDTH(32),
        .CNT_WIDTH(4), .NUM_EVT(4), .HALT_REPEAT(1)
    ) dut4 (
        .clk(clk), .reset(reset4), .pc_i(pc4), .pc_valid_i(pc_valid4), .evt_i(evt4),
        .core_reset_o(core_reset4), .run_o(run4), .done_o(done4), .timeout_o(timeout4),
        .state_o(state4), .cycle_cnt_o(cycle_cnt4), .evt_cnt_o(evt_cnt4)
    );

    run_ctrl_sat_cnt #(.CNT_WIDTH(4)) u_sc (
        .clk(clk), .reset(sc_reset), .en(sc_en), .cnt(sc_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic exp_t mk(int p, bit cr, bit rn, bit dn, bit to, int st, int cnt);
        exp_t e;
        e.p = p; e.cr = cr; e.run = rn; e.done = dn; e.to = to;
        e.st = 2'(st); e.cnt = 16'(cnt);
        return e;
    endfunction

    // Expected outputs after the p-th rising edge following reset release (RST_CYCLES=2).
    function automatic exp_t runExp(int p, int halt_p);
        if (p < 2)                         return mk(p, 1, 0, 0, 0, 0, 0);
        else if (halt_p > 0 && p >= halt_p) return mk(p, 0, 0, 1, 0, 2, halt_p - 2);
        else if (p >= MAXC + 2)            return mk(p, 0, 0, 0, 1, 3, MAXC);
        else                               return mk(p, 0, 1, 0, 0, 1, p - 2);
    endfunction

    task automatic cmp(input string name, input int p, input logic [31:0] got,
                       input logic [31:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("[TB] FAIL %s cycle %0d: got %0h, expected %0h", name, p, got, exp);
        end
    endtask

    task automatic checkOutput(input string name, input exp_t e);
        cmp({name, ".core_reset"}, e.p, 32'(core_reset), 32'(e.cr));
        cmp({name, ".run"},        e.p, 32'(run),        32'(e.run));
        cmp({name, ".done"},       e.p, 32'(done),       32'(e.done));
        cmp({name, ".timeout"},    e.p, 32'(timeout),    32'(e.to));
        cmp({name, ".state"},      e.p, 32'(state),      32'(e.st));
        cmp({name, ".cycle_cnt"},  e.p, 32'(cycle_cnt),  32'(e.cnt));
    endtask

    // Call at a falling edge: drive, let one rising edge pass, then score the result.
    task automatic applyStimulus(input string name, input logic v, input logic [31:0] p_pc,
                                 input logic [3:0] p_evt, input exp_t e);
        exp_t got_e;
        pc_valid = v;
        pc       = p_pc;
        evt      = p_evt;
        sb_q.push_back(e);
        @(posedge clk);
        @(negedge clk);
        got_e = sb_q.pop_front();
        checkOutput(name, got_e);
    endtask

    task automatic startRun();
        pc_valid = 1'b0;
        pc       = '0;
        evt      = '0;
        reset    = 1'b0;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1;
    endtask

    initial begin
        tests_run    = 0;
        tests_failed = 0;
        reset = 1'b0; pc = '0; pc_valid = 1'b0; evt = '0;
        reset4 = 1'b0; pc4 = '0; pc_valid4 = 1'b0; evt4 = '0;
        sc_reset = 1'b0; sc_en = 1'b0;

        tbl[0]  = '{1'b0, 32'h0,   mk(1,  1, 0, 0, 0, 0, 0)};
        tbl[1]  = '{1'b0, 32'h0,   mk(2,  0, 1, 0, 0, 1, 0)};
        tbl[2]  = '{1'b1, 32'h0,   mk(3,  0, 1, 0, 0, 1, 1)};
        tbl[3]  = '{1'b1, 32'h4,   mk(4,  0, 1, 0, 0, 1, 2)};
        tbl[4]  = '{1'b1, 32'h8,   mk(5,  0, 1, 0, 0, 1, 3)};
        tbl[5]  = '{1'b1, 32'h8,   mk(6,  0, 1, 0, 0, 1, 4)};
        tbl[6]  = '{1'b0, 32'h100, mk(7,  0, 1, 0, 0, 1, 5)};
        tbl[7]  = '{1'b1, 32'h8,   mk(8,  0, 1, 0, 0, 1, 6)};
        tbl[8]  = '{1'b1, 32'h8,   mk(9,  0, 0, 1, 0, 2, 7)};
        tbl[9]  = '{1'b1, 32'h8,   mk(10, 0, 0, 1, 0, 2, 7)};
        tbl[10] = '{1'b0, 32'h0,   mk(11, 0, 0, 1, 0, 2, 7)};

        repeat (3) @(negedge clk);
        checkOutput("reset", mk(0, 1, 0, 0, 0, 0, 0));
        cmp("reset.evt_cnt", 0, evt_cnt[31:0], 32'h0);

        // Free-running PC: budget exhaustion, strobes counted through the final RUN edge.
        startRun();
        for (int p = 1; p <= 105; p++) begin
            applyStimulus("timeout", 1'b1, 32'(p * 4),
                          ((p % 2) == 0) ? 4'b0101 : 4'b0001, runExp(p, 0));
        end
        cmp("timeout.evt0", 105, 32'(evt_cnt[0*16 +: 16]), EVT_EN ? 32'd100 : 32'd0);
        cmp("timeout.evt1", 105, 32'(evt_cnt[1*16 +: 16]), 32'd0);
        cmp("timeout.evt2", 105, 32'(evt_cnt[2*16 +: 16]), EVT_EN ? 32'd50 : 32'd0);

        // Halt sequence from the table, including an invalid cycle between repeats.
        startRun();
        for (int i = 0; i < 11; i++) begin
            applyStimulus("halt", tbl[i].v, tbl[i].pc, 4'b0000, tbl[i].e);
        end

        // Third repeat lands on the last budget cycle: halt must win.
        startRun();
        for (int p = 1; p <= 104; p++) begin
            applyStimulus("tie", 1'b1, (p <= 99) ? 32'(p * 4) : 32'd396, 4'b0000,
                          runExp(p, 102));
        end

        // Asynchronous reset mid-RUN, then a clean restart.
        startRun();
        for (int p = 1; p <= 52; p++) begin
            applyStimulus("midrun", 1'b1, 32'(p * 4), 4'b0001, runExp(p, 0));
        end
        cmp("midrun.evt0", 52, 32'(evt_cnt[15:0]), EVT_EN ? 32'd50 : 32'd0);
        #2;
        reset = 1'b0;
        #1;
        checkOutput("midrun_reset", mk(0, 1, 0, 0, 0, 0, 0));
        cmp("midrun_reset.evt0", 0, 32'(evt_cnt[15:0]), 32'd0);
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1;
        for (int p = 1; p <= 4; p++) begin
            applyStimulus("restart", 1'b1, 32'(p * 4), 4'b0001, runExp(p, 0));
        end
        cmp("restart.evt0", 4, 32'(evt_cnt[15:0]), EVT_EN ? 32'd2 : 32'd0);

        // Narrow instance: RST_CYCLES=1, 4-bit counters, evt[1] held for 20 cycles.
        @(negedge clk);
        reset4 = 1'b1;
        evt4   = 4'b0010;
        @(posedge clk);
        @(negedge clk);
        cmp("narrow.core_reset", 1, 32'(core_reset4), 32'd0);
        cmp("narrow.run", 1, 32'(run4), 32'd1);
        cmp("narrow.state", 1, 32'(state4), 32'd1);
        repeat (19) @(negedge clk);
        cmp("narrow.timeout", 20, 32'(timeout4), 32'd1);
        cmp("narrow.run_end", 20, 32'(run4), 32'd0);
        cmp("narrow.done", 20, 32'(done4), 32'd0);
        cmp("narrow.cycle_cnt", 20, 32'(cycle_cnt4), 32'd15);
        cmp("narrow.evt1", 20, 32'(evt_cnt4[7:4]), EVT_EN ? 32'd15 : 32'd0);
        cmp("narrow.evt0", 20, 32'(evt_cnt4[3:0]), 32'd0);
        evt4 = 4'b0000;

        // Standalone saturating counter: 20 enables must stop at 15.
        sc_reset = 1'b1;
        sc_en    = 1'b1;
        repeat (7) @(negedge clk);
        cmp("satcnt.mid", 7, 32'(sc_cnt), 32'd7);
        repeat (13) @(negedge clk);
        cmp("satcnt.sat", 20, 32'(sc_cnt), 32'd15);
        #2;
        sc_reset = 1'b0;
        #1;
        cmp("satcnt.clear", 20, 32'(sc_cnt), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
